// File: rtl/alu_dispatch_sched.sv
// alu_dispatch_sched -- in-order dispatch queue feeding two ALU reservation slots.
//
// Ops from the decoder are held in a DEPTH-entry circular FIFO and issued in
// program order, up to two per cycle, to whichever reservation slots are free.
// The oldest op goes to the preferred slot, the next one to the other slot.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   rdy                 global enable; low freezes the queue and drops strobes
//   flush               discard every queued, undispatched op
//   in_valid/in_ready   decoder handshake; in_pc, in_op, in_tag{x,y,w},
//                       in_data{x,y}, in_addrw carry the op payload
//   slot_busy0/1        reservation slot occupancy
//   en0/en1             one-cycle issue strobes; pc/op/tag/data/addrw 0/1 are
//                       the registered payload, held when the slot is idle
//
// Optional feature: define ALU_DISPATCH_RR_EN to rotate the preferred slot
// after each single issue made while both slots were free. Without it, slot 0
// is always preferred.

`ifndef ADDR_T
`define ADDR_T logic [31:0]
`endif
`ifndef SINST_T
`define SINST_T logic [31:0]
`endif
`ifndef REGTAG_T
`define REGTAG_T logic [3:0]
`endif
`ifndef DWORD_T
`define DWORD_T logic [31:0]
`endif
`ifndef REGADDR_T
`define REGADDR_T logic [4:0]
`endif
`ifndef UNLOCKED
`define UNLOCKED 4'hF
`endif

module alu_dispatch_sched #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rdy,
    input  logic       flush,
    input  logic       in_valid,
    output logic       in_ready,
    input  `ADDR_T     in_pc,
    input  `SINST_T    in_op,
    input  `REGTAG_T   in_tagx,
    input  `REGTAG_T   in_tagy,
    input  `REGTAG_T   in_tagw,
    input  `DWORD_T    in_datax,
    input  `DWORD_T    in_datay,
    input  `REGADDR_T  in_addrw,
    input  logic       slot_busy0,
    input  logic       slot_busy1,
    output logic       en0,
    output `ADDR_T     pc0,
    output `SINST_T    op0,
    output `REGTAG_T   tagx0,
    output `REGTAG_T   tagy0,
    output `REGTAG_T   tagw0,
    output `DWORD_T    datax0,
    output `DWORD_T    datay0,
    output `REGADDR_T  addrw0,
    output logic       en1,
    output `ADDR_T     pc1,
    output `SINST_T    op1,
    output `REGTAG_T   tagx1,
    output `REGTAG_T   tagy1,
    output `REGTAG_T   tagw1,
    output `DWORD_T    datax1,
    output `DWORD_T    datay1,
    output `REGADDR_T  addrw1
);

    localparam int PW = $clog2(DEPTH);

    typedef struct packed {
        `ADDR_T    pc;
        `SINST_T   op;
        `REGTAG_T  tagx;
        `REGTAG_T  tagy;
        `REGTAG_T  tagw;
        `DWORD_T   datax;
        `DWORD_T   datay;
        `REGADDR_T addrw;
    } entry_t;

    entry_t         mem [DEPTH];
    entry_t         slot_q [2];
    entry_t         in_entry;
    entry_t         rst_entry;
    logic [PW:0]    count;
    logic [PW-1:0]  head;
    logic [PW-1:0]  tail;
    logic [PW-1:0]  head1;
    logic [1:0]     en;
    logic           free0, free1;
    logic [1:0]     nfree;
    logic [1:0]     n;
    logic           pref;
    logic           first_slot;
    logic           accept;

    assign in_entry = '{pc: in_pc, op: in_op, tagx: in_tagx, tagy: in_tagy,
                        tagw: in_tagw, datax: in_datax, datay: in_datay,
                        addrw: in_addrw};
    assign rst_entry = '{pc: '0, op: '0, tagx: `UNLOCKED, tagy: `UNLOCKED,
                         tagw: `UNLOCKED, datax: '0, datay: '0, addrw: '0};

    // count is the pre-edge value, so a full queue never accepts even when it
    // is about to drain this same edge.
    assign in_ready = !rst && rdy && !flush && (count != (PW+1)'(DEPTH));
    assign accept   = in_valid && in_ready;

    assign free0 = !slot_busy0;
    assign free1 = !slot_busy1;
    assign head1 = head + 1'b1;

    always_comb begin
        nfree = {1'b0, free0} + {1'b0, free1};
        n     = nfree;
        if (count < (PW+1)'(nfree))
            n = count[1:0];
        // With both free the oldest op takes the preferred slot; with one free
        // it takes whichever is free.
        first_slot = (free0 && free1) ? pref : free1;
    end

`ifdef ALU_DISPATCH_RR_EN
    logic rr;
    always_ff @(posedge clk) begin
        if (rst)
            rr <= 1'b0;
        else if (!flush && rdy && n == 2'd1 && free0 && free1)
            rr <= ~rr;
    end
    assign pref = rr;
`else
    assign pref = 1'b0;
`endif

    // Storage needs no reset; accept already excludes rst and flush.
    always_ff @(posedge clk) begin
        if (accept)
            mem[tail] <= in_entry;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count     <= '0;
            head      <= '0;
            tail      <= '0;
            en        <= '0;
            slot_q[0] <= rst_entry;
            slot_q[1] <= rst_entry;
        end else if (flush) begin
            count <= '0;
            head  <= '0;
            tail  <= '0;
            en    <= '0;
        end else if (!rdy) begin
            en <= '0;
        end else begin
            en <= '0;
            if (accept)
                tail <= tail + 1'b1;
            if (n != 2'd0) begin
                en[first_slot]     <= 1'b1;
                slot_q[first_slot] <= mem[head];
            end
            if (n == 2'd2) begin
                en[~first_slot]     <= 1'b1;
                slot_q[~first_slot] <= mem[head1];
            end
            head  <= head + PW'(n);
            count <= count + (PW+1)'(accept) - (PW+1)'(n);
        end
    end

    assign en0    = en[0];
    assign pc0    = slot_q[0].pc;
    assign op0    = slot_q[0].op;
    assign tagx0  = slot_q[0].tagx;
    assign tagy0  = slot_q[0].tagy;
    assign tagw0  = slot_q[0].tagw;
    assign datax0 = slot_q[0].datax;
    assign datay0 = slot_q[0].datay;
    assign addrw0 = slot_q[0].addrw;
    assign en1    = en[1];
    assign pc1    = slot_q[1].pc;
    assign op1    = slot_q[1].op;
    assign tagx1  = slot_q[1].tagx;
    assign tagy1  = slot_q[1].tagy;
    assign tagw1  = slot_q[1].tagw;
    assign datax1 = slot_q[1].datax;
    assign datay1 = slot_q[1].datay;
    assign addrw1 = slot_q[1].addrw;

endmodule

// File: tb/tb_alu_dispatch_sched.sv
// Directed bench for alu_dispatch_sched: reset state, single issue, dual
// issue from a full queue, single free slot, slot preference, flush, stall.
module tb_alu_dispatch_sched;

    localparam logic [3:0] UNLOCKED = 4'hF;

    logic        clk = 1'b0;
    logic        rst, rdy, flush, in_valid, in_ready;
    logic [31:0] in_pc, in_op, in_datax, in_datay;
    logic [3:0]  in_tagx, in_tagy, in_tagw;
    logic [4:0]  in_addrw;
    logic        slot_busy0, slot_busy1;
    logic        en0, en1;
    logic [31:0] pc0, op0, datax0, datay0, pc1, op1, datax1, datay1;
    logic [3:0]  tagx0, tagy0, tagw0, tagx1, tagy1, tagw1;
    logic [4:0]  addrw0, addrw1;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    alu_dispatch_sched #(.DEPTH(4)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_op(in_op), .in_tagx(in_tagx), .in_tagy(in_tagy),
        .in_tagw(in_tagw), .in_datax(in_datax), .in_datay(in_datay),
        .in_addrw(in_addrw),
        .slot_busy0(slot_busy0), .slot_busy1(slot_busy1),
        .en0(en0), .pc0(pc0), .op0(op0), .tagx0(tagx0), .tagy0(tagy0),
        .tagw0(tagw0), .datax0(datax0), .datay0(datay0), .addrw0(addrw0),
        .en1(en1), .pc1(pc1), .op1(op1), .tagx1(tagx1), .tagy1(tagy1),
        .tagw1(tagw1), .datax1(datax1), .datay1(datay1), .addrw1(addrw1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock; outputs are sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_op(input logic [31:0] pc);
        in_valid = 1'b1;
        in_pc    = pc;
        in_op    = pc ^ 32'hA5A5_0000;
        in_datax = pc + 32'd1;
        in_datay = pc + 32'd2;
        in_tagx  = pc[3:0];
        in_tagy  = 4'd1;
        in_tagw  = 4'd2;
        in_addrw = pc[6:2];
    endtask

    task automatic do_reset();
        rst = 1'b1; rdy = 1'b1; flush = 1'b0; in_valid = 1'b0;
        slot_busy0 = 1'b0; slot_busy1 = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        int exp_slot;
        in_pc = '0; in_op = '0; in_datax = '0; in_datay = '0;
        in_tagx = '0; in_tagy = '0; in_tagw = '0; in_addrw = '0;
        in_valid = 1'b0;

        // Reset state
        do_reset();
        rst = 1'b1;
        #1;
        chk("rst_in_ready", in_ready, 0);
        rst = 1'b0;
        #1;
        chk("rst_en0", en0, 0);
        chk("rst_en1", en1, 0);
        chk("rst_pc0", pc0, 0);
        chk("rst_tagx0", tagx0, UNLOCKED);
        chk("rst_tagw1", tagw1, UNLOCKED);
        chk("rst_datax1", datax1, 0);
        chk("rst_in_ready_after", in_ready, 1);

        // Single op, both slots free: no bypass, issues one cycle after accept
        drive_op(32'h100);
        step();
        in_valid = 1'b0;
        chk("one_no_bypass", en0, 0);
        step();
        chk("one_en0", en0, 1);
        chk("one_pc0", pc0, 32'h100);
        chk("one_datay0", datay0, 32'h102);
        chk("one_en1", en1, 0);
        step();
        chk("one_en0_pulse", en0, 0);

        // Fill the queue with both slots busy, then drain two per cycle
        do_reset();
        slot_busy0 = 1'b1; slot_busy1 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive_op(32'h10 + 32'(4 * i));
            step();
        end
        in_valid = 1'b0;
        chk("full_in_ready", in_ready, 0);
        chk("full_count", 32'(dut.count), 4);
        slot_busy0 = 1'b0; slot_busy1 = 1'b0;
        step();
        chk("dual_a_en0", en0, 1);
        chk("dual_a_pc0", pc0, 32'h10);
        chk("dual_a_en1", en1, 1);
        chk("dual_a_pc1", pc1, 32'h14);
        chk("dual_a_ready", in_ready, 1);
        step();
        chk("dual_b_en0", en0, 1);
        chk("dual_b_pc0", pc0, 32'h18);
        chk("dual_b_en1", en1, 1);
        chk("dual_b_pc1", pc1, 32'h1C);
        chk("dual_b_addrw1", addrw1, 5'(32'h1C >> 2));
        step();
        chk("dual_idle_en0", en0, 0);
        chk("dual_idle_en1", en1, 0);
        chk("dual_idle_pc1_held", pc1, 32'h1C);

        // Only slot 1 free: oldest op goes to slot 1, the other stays queued
        do_reset();
        slot_busy0 = 1'b1; slot_busy1 = 1'b1;
        drive_op(32'h20); step();
        drive_op(32'h24); step();
        in_valid = 1'b0;
        slot_busy1 = 1'b0;
        step();
        chk("one_free_en0", en0, 0);
        chk("one_free_en1", en1, 1);
        chk("one_free_pc1", pc1, 32'h20);
        chk("one_free_count", 32'(dut.count), 1);
        slot_busy1 = 1'b1;
        step();
        chk("one_free_hold_en1", en1, 0);
        chk("one_free_hold_count", 32'(dut.count), 1);

        // Slot preference across three single issues
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive_op(32'h30 + 32'(4 * i));
            step();
            in_valid = 1'b0;
            step();
`ifdef ALU_DISPATCH_RR_EN
            exp_slot = i % 2;
`else
            exp_slot = 0;
`endif
            chk("pref_en0", en0, (exp_slot == 0) ? 1 : 0);
            chk("pref_en1", en1, (exp_slot == 1) ? 1 : 0);
            chk("pref_pc", (exp_slot == 0) ? pc0 : pc1, 32'h30 + 32'(4 * i));
        end

        // Flush with a same-edge enqueue
        do_reset();
        slot_busy0 = 1'b1; slot_busy1 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive_op(32'h50 + 32'(4 * i));
            step();
        end
        drive_op(32'h99);
        flush = 1'b1;
        slot_busy0 = 1'b0; slot_busy1 = 1'b0;
        #1;
        chk("flush_in_ready", in_ready, 0);
        step();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_count", 32'(dut.count), 0);
        chk("flush_en0", en0, 0);
        chk("flush_en1", en1, 0);
        step();
        chk("flush_no_new_en0", en0, 0);
        chk("flush_no_new_en1", en1, 0);
        chk("flush_no_new_count", 32'(dut.count), 0);

        // Stall with rdy low, then release
        do_reset();
        slot_busy0 = 1'b1; slot_busy1 = 1'b1;
        drive_op(32'h40); step();
        drive_op(32'h44); step();
        in_valid = 1'b0;
        rdy = 1'b0;
        slot_busy0 = 1'b0; slot_busy1 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_en0", en0, 0);
            chk("stall_en1", en1, 0);
            chk("stall_count", 32'(dut.count), 2);
        end
        rdy = 1'b1;
        step();
        chk("release_en0", en0, 1);
        chk("release_pc0", pc0, 32'h40);
        chk("release_en1", en1, 1);
        chk("release_pc1", pc1, 32'h44);
        chk("release_count", 32'(dut.count), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/alu_dispatch_sched.md
ALU_DISPATCH_SCHED -- requirements
Module: alu_dispatch_sched

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning dispatch FIFO entries (power of two, 2..16).
REQ-002 SHALL have ports clk input 1, the clock, and rst input 1, the reset; reset rst, synchronous, active-high; clock clk.
REQ-003 SHALL have rdy input 1, global enable; flush input 1, discard all queued, undispatched ops.
REQ-004 SHALL have in_valid input 1 (decoder offers ALU op) and in_ready output 1 (op accepted when both high at posedge).
REQ-005 SHALL have in_pc input `addr_t; in_op input `sinst_t; in_tagx/in_tagy/in_tagw input `regtag_t; in_datax/in_datay input `dword_t; in_addrw input `regaddr_t, the op payload.
REQ-006 SHALL have slot_busy0/slot_busy1 input 1, busy flags of ALU reservation slots 0/1.
REQ-007 SHALL have, per slot k in {0,1}: enk output 1 (one-cycle issue strobe) plus pck, opk, tagxk, tagyk, tagwk, dataxk, datayk, addrwk outputs, same widths as the in_* payload.

Function
REQ-008 SHALL hold ops in a DEPTH-entry circular FIFO with head/tail pointers of log2(DEPTH) bits, wrapping from DEPTH-1 to 0, and a count from 0 to DEPTH.
REQ-009 SHALL drive in_ready = rdy & !flush & (count != DEPTH), where count is the registered value before this edge's dispatch.
REQ-010 SHALL write the accepted op at tail and increment tail on the posedge; the op becomes dispatchable at the following posedge, so minimum accept-to-enk latency is 1 cycle.
REQ-011 SHALL treat slot k as free at a posedge when slot_busyk == 0.
REQ-012 SHALL at each posedge with rdy=1 and flush=0 dispatch n = min(count, free slot count), with n in {0,1,2}, ops in FIFO order from head.
REQ-013 SHALL send head to the preferred free slot and head+1 to the other free slot when n=2; slot preference is per REQ-024/025.
REQ-014 SHALL register enk and payload at that posedge; enk is high for exactly one cycle per dispatched op; unused slot payload outputs hold their previous values.
REQ-015 SHALL advance head by n and update count = count + accepted - n at the same edge; simultaneous enqueue and dispatch are legal at any count, including full with dispatch (no accept that edge, per REQ-009).
REQ-016 SHALL never dispatch when count == 0; enqueue into an empty FIFO does not bypass to the outputs.
REQ-017 SHALL on a posedge with flush=1 clear count, head, tail, en0 and en1; flush overrides same-edge enqueue and dispatch.
REQ-018 SHALL on a posedge with rdy=0 clear en0 and en1, and hold the FIFO, pointers and count.
REQ-019 SHALL preserve program order: an op is never dispatched before an older queued op.

Reset
REQ-020 SHALL on posedge with rst=1 clear count, head, tail, en0, en1, pc0/pc1, op0/op1, data outputs and addrw outputs to 0.
REQ-021 SHALL on reset set tag outputs to `UNLOCKED and the round-robin pointer to slot 0.
REQ-022 SHALL give rst priority over flush and rdy; reset mid-operation discards queued ops.
REQ-023 SHALL drive in_ready = 0 while rst=1.

Configuration
REQ-024 SHALL, with ALU_DISPATCH_RR_EN defined, keep a 1-bit preferred-slot pointer that toggles after every edge where exactly one op is dispatched while both slots were free; otherwise it holds.
REQ-025 SHALL, without ALU_DISPATCH_RR_EN, make slot 0 always preferred when free, with no pointer register.

Verification
REQ-026 SHALL cover: reset, then one op pc=0x100 with both slots free -> en0=1 one cycle after accept, pc0=0x100, en1=0.
REQ-027 SHALL cover: 4 ops pc=0x10,0x14,0x18,0x1C with both slots busy -> in_ready=0 after the 4th; free both slots -> 0x10 on slot 0 and 0x14 on slot 1 same cycle, then 0x18/0x1C the next cycle.
REQ-028 SHALL cover: slot_busy0=1, slot_busy1=0, two queued ops -> only the older op issues on en1; the other stays queued, count=1.
REQ-029 SHALL cover: with ALU_DISPATCH_RR_EN, three single ops each with both slots free -> issued on slots 0,1,0; without it -> 0,0,0.
REQ-030 SHALL cover: 3 queued ops, flush with in_valid=1 -> count=0, no enk next cycle, new op not stored.
REQ-031 SHALL cover: rdy=0 for 3 cycles with 2 queued ops and free slots -> en0=en1=0 and count=2 held; rdy=1 -> both ops issue on the next edge.
